dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port word-addressed data memory between the pipeline MEM stage (CPU port)
//   and a DMA/debug loader port (DMA port). Grants at most one access per cycle and drives the
//   memory's address/write_data/wen/ren. Returns read data with fixed 1-cycle latency.
//   Stalls the pipeline while the CPU is denied. CPU has fixed priority, with a starvation guard for DMA.
// PARAMETERS
//   DATA_W    32    data width of both ports and the memory
//   ADDR_W    32    address width; word address, passed to memory unmodified
//   DEPTH     1024  memory words; addr >= DEPTH is out of range
//   MAX_WAIT  4     consecutive denied DMA cycles before DMA is forced to win (1..15)
// PORTS
//   clk            in   1       clock, all state on posedge
//   reset          in   1       synchronous, active-high
//   cpu_req        in   1       CPU access request; held with cmd stable until cpu_gnt
//   cpu_we         in   1       1=store, 0=load
//   cpu_addr       in   ADDR_W  CPU word address
//   cpu_wdata      in   DATA_W  CPU store data
//   cpu_gnt        out  1       CPU access performed this cycle (combinational)
//   cpu_stall      out  1       cpu_req & ~cpu_gnt, to hazard unit
//   cpu_rvalid     out  1       CPU load data valid (cycle after grant)
//   cpu_rdata      out  DATA_W  registered CPU load data
//   dma_req/we/addr/wdata  in   1/1/ADDR_W/DATA_W  same semantics as CPU port
//   dma_gnt, dma_rvalid    out  1     as CPU port
//   dma_rdata      out  DATA_W  registered DMA load data
//   dma_lock       in   1       while 1 and DMA holds ownership, CPU is locked out (burst)
//   err            out  1       registered pulse: granted access was out of range
//   mem_address    out  ADDR_W  to data memory
//   mem_write_data out  DATA_W  to data memory
//   mem_wen        out  1       to data memory
//   mem_ren        out  1       to data memory
//   mem_read_data  in   DATA_W  from data memory, combinational read
// BEHAVIOUR
//   - Owner state: OWN_NONE/OWN_CPU/OWN_DMA, registered. It records the last grant.
//   - Grant (combinational) in priority order:
//       (a) owner==OWN_DMA & dma_lock & dma_req -> DMA;
//       (b) dma_req & wait_cnt==MAX_WAIT -> DMA;
//       (c) cpu_req -> CPU;
//       (d) dma_req -> DMA;
//       (e) none.
//     Both requesting with wait_cnt<MAX_WAIT and no lock -> CPU.
//   - Owner updates to the granted port. With no grant, owner holds unless dma_lock==0; then it goes to OWN_NONE.
//   - wait_cnt:
//       dma_req & ~dma_gnt -> +1, saturating at MAX_WAIT;
//       dma_gnt or ~dma_req -> 0.
//   - mem_* are muxed from the granted port.
//     No grant -> address 0, data 0, wen=ren=0.
//     Out-of-range grant -> wen=ren=0.
//   - Load grant: capture mem_read_data (0 if out of range) into <port>_rdata at the posedge.
//     <port>_rvalid=1 for exactly the next cycle. Store grant: no rvalid.
//   - rdata holds its value until the next load grant to that port.
//   - err=1 for one cycle after any out-of-range grant. The grant is still given so the requester does not hang.
//   - Reset (any cycle, mid-burst included): owner=OWN_NONE, wait_cnt=0, rvalid=0, rdata=0, err=0.
//     While reset=1: all gnt=0 and mem_wen=mem_ren=0, so no write reaches memory during its own reset clear.
//     Outstanding requests are dropped; requesters re-present after reset.
//   - Back-to-back grants to the same port are allowed every cycle (throughput 1/cycle total).
// STRUCTURE
//   - dmem_pkg: owner_t enum {OWN_NONE, OWN_CPU, OWN_DMA}, DMEM_DEPTH=1024, MAX_WAIT default.
//   - Sub-module arb_wait_counter: saturating counter with inc/clr/sat ports, width $clog2(MAX_WAIT+1).
//   - Top level holds the grant logic, owner register, mem mux and the response registers.
// TESTING
//   1. CPU store addr 3 data 0xDEAD, then load addr 3
//      -> cpu_gnt both cycles, mem_wen then mem_ren;
//      cpu_rvalid 1 cycle after the load; cpu_rdata=0xDEAD.
//   2. cpu_req and dma_req held high continuously, MAX_WAIT=4
//      -> CPU granted 4 cycles, DMA 5th;
//      pattern repeats; cpu_stall=1 exactly on the DMA cycles.
//   3. DMA holds owner with dma_lock=1 for 3 loads (addr 0,1,2) while cpu_req=1
//      -> dma_rdata 70,71,72 on consecutive cycles;
//      cpu_stall=1 throughout; CPU granted the cycle after dma_lock drops.
//   4. DMA load addr 1024
//      -> dma_gnt=1, mem_ren=0, dma_rvalid=1 with dma_rdata=0, err pulses once.
//   5. Assert reset mid-burst with a store pending
//      -> mem_wen=0 during reset, all outputs at reset values next cycle,
//      wait_cnt=0, memory word unchanged.
//   6. DMA only, dma_req toggling every cycle
//      -> every request granted immediately; wait_cnt stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam int DMEM_DEPTH    = 1024;
    localparam int DMEM_MAX_WAIT = 4;

    // Counter width able to hold 0..max_wait inclusive.
    function automatic int wait_cnt_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating count of consecutive cycles the DMA port was denied.
// Latency: count updates on the clock edge after inc/clr.
// Backpressure: none; inc is ignored once saturated, clr wins over inc.
module arb_wait_counter
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = wait_cnt_width(MAX_WAIT);

    logic [CW-1:0] count;

    assign sat = (count == CW'(MAX_WAIT));

    // Count denied cycles, hold at MAX_WAIT, clear on grant or idle.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a DMA/debug port.
// Latency: grant and mem_* are combinational; load data and err return one cycle after grant.
// Backpressure: CPU wins by default; DMA wins while locked-owner or after MAX_WAIT denied cycles.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = DMEM_DEPTH,
    parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    input  logic              dma_lock,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_read_data
);

    owner_t owner, owner_nxt;

    logic              wait_sat;
    logic              lock_win;
    logic              force_dma;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .inc   (dma_req && !dma_gnt),
        .clr   (!dma_req || dma_gnt),
        .sat   (wait_sat)
    );

    // A locked burst owner or a starved DMA pre-empts the CPU; reset blocks every grant.
    assign lock_win  = (owner == OWN_DMA) && dma_lock && dma_req;
    assign force_dma = dma_req && wait_sat;
    assign dma_gnt   = !reset && (lock_win || force_dma || (dma_req && !cpu_req));
    assign cpu_gnt   = !reset && cpu_req && !lock_win && !force_dma;
    assign cpu_stall = cpu_req && !cpu_gnt;
    assign any_gnt   = cpu_gnt || dma_gnt;

    // Route the granted port's command to memory; idle drives zeros.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (cpu_gnt) begin
            sel_we    = cpu_we;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
    end

    // Out-of-range accesses are still granted but never touch the memory.
    assign in_range       = (sel_addr < ADDR_W'(DEPTH));
    assign mem_address    = sel_addr;
    assign mem_write_data = sel_wdata;
    assign mem_wen        = any_gnt && sel_we && in_range;
    assign mem_ren        = any_gnt && !sel_we && in_range;
    assign rd_word        = in_range ? mem_read_data : '0;

    // Owner register.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    // Owner follows the last grant; an idle cycle without lock releases ownership.
    always_comb begin
        owner_nxt = owner;
        if (cpu_gnt) begin
            owner_nxt = OWN_CPU;
        end else if (dma_gnt) begin
            owner_nxt = OWN_DMA;
        end else if (!dma_lock) begin
            owner_nxt = OWN_NONE;
        end
    end

    // Load responses and the out-of-range error pulse, one cycle after the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
            err        <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dma_rvalid <= dma_gnt && !dma_we;
            err        <= any_gnt && !in_range;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= rd_word;
            end
            if (dma_gnt && !dma_we) begin
                dma_rdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed checks of dmem_arbiter against a behavioural model.
// Latency: model predicts grants in-cycle and responses one cycle later.
// Backpressure: model applies priority rules with a plain denied-cycle count.
module tb_dmem_arbiter;

    localparam int MAXW = 4;
    localparam int NW   = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_wen, mem_ren;

    int checks = 0;
    int errors = 0;

    // Physical memory seen by the DUT, and the model's own copy.
    logic [31:0] phys_mem [NW];
    logic [31:0] ref_mem  [NW];

    // Model state: 0 none, 1 cpu, 2 dma.
    int          m_owner;
    int          m_wait;
    logic        m_known;
    logic        m_crv, m_drv, m_err;
    logic [31:0] m_crd, m_drd;

    // Last observed values for directed checks.
    logic obs_cg, obs_dg, obs_wen, obs_stall;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_gnt        (cpu_gnt),
        .cpu_stall      (cpu_stall),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_rdata      (cpu_rdata),
        .dma_req        (dma_req),
        .dma_we         (dma_we),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .dma_gnt        (dma_gnt),
        .dma_rvalid     (dma_rvalid),
        .dma_rdata      (dma_rdata),
        .dma_lock       (dma_lock),
        .err            (err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_wen        (mem_wen),
        .mem_ren        (mem_ren),
        .mem_read_data  (mem_read_data)
    );

    // Combinational-read memory; out-of-range reads return junk so the DUT must zero them.
    assign mem_read_data = (mem_address < NW) ? phys_mem[mem_address[9:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_wen && mem_address < NW) phys_mem[mem_address[9:0]] <= mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic cycle();
        logic        forced, cg, dg, we, inr, e_wen, e_ren;
        logic [31:0] a, d;
        #1;
        forced = !reset && dma_req && ((m_owner == 2 && dma_lock) || m_wait == MAXW);
        dg     = !reset && (forced || (dma_req && !cpu_req));
        cg     = !reset && cpu_req && !forced;
        a      = cg ? cpu_addr  : (dg ? dma_addr  : 32'd0);
        d      = cg ? cpu_wdata : (dg ? dma_wdata : 32'd0);
        we     = cg ? cpu_we    : (dg ? dma_we    : 1'b0);
        inr    = (a < NW);
        e_wen  = (cg || dg) && we && inr;
        e_ren  = (cg || dg) && !we && inr;

        chk("cpu_gnt", cpu_gnt, cg);
        chk("dma_gnt", dma_gnt, dg);
        chk("cpu_stall", cpu_stall, cpu_req && !cg);
        chk("mem_address", mem_address, a);
        chk("mem_write_data", mem_write_data, d);
        chk("mem_wen", mem_wen, e_wen);
        chk("mem_ren", mem_ren, e_ren);
        if (m_known) begin
            chk("cpu_rvalid", cpu_rvalid, m_crv);
            chk("cpu_rdata", cpu_rdata, m_crd);
            chk("dma_rvalid", dma_rvalid, m_drv);
            chk("dma_rdata", dma_rdata, m_drd);
            chk("err", err, m_err);
        end
        obs_cg = cpu_gnt; obs_dg = dma_gnt; obs_wen = mem_wen; obs_stall = cpu_stall;

        if (reset) begin
            m_owner = 0; m_wait = 0; m_known = 1'b1;
            m_crv = 0; m_drv = 0; m_err = 0; m_crd = 0; m_drd = 0;
        end else begin
            m_crv = cg && !cpu_we;
            m_drv = dg && !dma_we;
            if (m_crv) m_crd = inr ? ref_mem[a[9:0]] : 32'd0;
            if (m_drv) m_drd = inr ? ref_mem[a[9:0]] : 32'd0;
            m_err = (cg || dg) && !inr;
            if (e_wen) ref_mem[a[9:0]] = d;
            if (cg)             m_owner = 1;
            else if (dg)        m_owner = 2;
            else if (!dma_lock) m_owner = 0;
            if (dma_req && !dg) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
            else                m_wait = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic lock);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d; dma_lock = lock;
    endtask

    initial begin
        int n_dma, n_stall, bad;
        for (int i = 0; i < NW; i++) begin
            phys_mem[i] = 32'(70 + i);
            ref_mem[i]  = 32'(70 + i);
        end
        m_known = 1'b0; m_owner = 0; m_wait = 0;
        m_crv = 0; m_drv = 0; m_err = 0; m_crd = 0; m_drd = 0;
        reset = 1'b1;
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        @(negedge clk);
        cycle();
        reset = 1'b0;
        cycle();
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_err", err, 0);

        // 1: CPU store then load of address 3.
        set_cpu(1, 1, 3, 32'hDEAD);
        cycle();
        chk("t1_store_wen", obs_wen, 1);
        set_cpu(1, 0, 3, 0);
        cycle();
        chk("t1_load_gnt", obs_cg, 1);
        chk("t1_rvalid", cpu_rvalid, 1);
        chk("t1_rdata", cpu_rdata, 32'hDEAD);
        set_cpu(0, 0, 0, 0);
        cycle();
        chk("t1_rvalid_drop", cpu_rvalid, 0);

        // 2: both requesting continuously; DMA every fifth cycle.
        n_dma = 0; n_stall = 0;
        set_cpu(1, 0, 20, 0);
        set_dma(1, 0, 21, 0, 0);
        for (int i = 0; i < 15; i++) begin
            cycle();
            chk("t2_pattern", obs_dg, (i % 5 == 4));
            n_dma += obs_dg;
            n_stall += obs_stall;
        end
        chk("t2_dma_count", n_dma, 3);
        chk("t2_stall_count", n_stall, 3);
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        cycle();

        // 3: locked DMA burst of three loads while CPU waits.
        for (int k = 0; k < 3; k++) begin
            set_dma(1, 0, 32'(k), 0, 1);
            if (k > 0) set_cpu(1, 0, 30, 0);
            cycle();
            chk("t3_dma_gnt", obs_dg, 1);
            chk("t3_rdata", dma_rdata, 32'(70 + k));
            if (k > 0) chk("t3_stall", obs_stall, 1);
        end
        set_dma(0, 0, 0, 0, 0);
        cycle();
        chk("t3_cpu_after", obs_cg, 1);
        set_cpu(0, 0, 0, 0);
        cycle();

        // 4: out-of-range DMA load.
        set_dma(1, 0, 1024, 0, 0);
        cycle();
        chk("t4_gnt", obs_dg, 1);
        chk("t4_rvalid", dma_rvalid, 1);
        chk("t4_rdata", dma_rdata, 0);
        chk("t4_err", err, 1);
        set_dma(0, 0, 0, 0, 0);
        cycle();
        chk("t4_err_pulse", err, 0);

        // 5: reset mid-burst with a CPU store pending, then wait count must restart.
        set_dma(1, 0, 8, 0, 1);
        cycle();
        set_cpu(1, 1, 5, 32'h1234);
        reset = 1'b1;
        cycle();
        chk("t5_wen_in_reset", obs_wen, 0);
        reset = 1'b0;
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        cycle();
        chk("t5_mem_kept", phys_mem[5], 32'd75);
        set_cpu(1, 0, 40, 0);
        set_dma(1, 0, 41, 0, 0);
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_wait_restart", obs_dg, (i == 4));
        end
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        cycle();

        // 6: DMA alone, request toggling every cycle.
        for (int i = 0; i < 10; i++) begin
            set_dma(i[0] ? 1'b0 : 1'b1, 1'($urandom), 32'($urandom_range(0, 15)), $urandom, 0);
            cycle();
            chk("t6_immediate", obs_dg, dma_req);
        end

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            set_cpu($urandom_range(0, 3) != 0, 1'($urandom),
                    ($urandom_range(0, 19) == 0) ? 32'(1024 + $urandom_range(0, 50)) : 32'($urandom_range(0, 15)),
                    $urandom);
            set_dma($urandom_range(0, 1) == 1, 1'($urandom),
                    ($urandom_range(0, 19) == 0) ? 32'(1024 + $urandom_range(0, 50)) : 32'($urandom_range(0, 15)),
                    $urandom, $urandom_range(0, 9) < 3);
            cycle();
        end
        reset = 1'b0;
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        cycle();

        bad = 0;
        for (int i = 0; i < NW; i++) if (phys_mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
